// File: rtl/filter_fir_mc.sv
// Multi-channel FIR with one time-shared MAC. Result and dataReady appear TAPS+2 cycles after acceptance.
// Backpressure: ready is high only in IDLE. Samples offered while busy are ignored, and coefficient writes made while busy are dropped.
module filter_fir_mc #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int TAPS     = 11,
  parameter int CHANNELS = 2,
  parameter int SHIFT    = 15,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int A_W     = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] inSignalUnReg,
  input  logic [CH_W-1:0]          inChannel,
  input  logic                     newData,
  output logic                     ready,
  input  logic                     coefWe,
  input  logic [A_W-1:0]           coefAddr,
  input  logic signed [COEF_W-1:0] coefData,
  output logic                     coefDrop,
  output logic signed [DATA_W-1:0] outSignal,
  output logic [CH_W-1:0]          outChannel,
  output logic                     dataReady
);

  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
  localparam int P_W   = DATA_W + COEF_W;
  localparam logic [A_W-1:0] LAST = A_W'(TAPS - 1);
  // The shift by SHIFT followed by a shift right by 1 yields 1<<(SHIFT-1), or 0 when SHIFT is 0.
  localparam logic signed [ACC_W:0] RND  = ((ACC_W+1)'(1) << SHIFT) >> 1;
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, WRITE, MAC, OUT} state_t;
  state_t state;

  logic signed [DATA_W-1:0] dline [CHANNELS][TAPS];
  logic [A_W-1:0]           ptr   [CHANNELS];
  logic signed [COEF_W-1:0] coef  [TAPS];

  logic [CH_W-1:0]          curCh;
  logic signed [DATA_W-1:0] sampleReg;
  logic [A_W-1:0]           tapIdx;
  logic [A_W-1:0]           rdIdx;
  logic signed [ACC_W-1:0]  acc;

  logic signed [P_W-1:0]    prod;
  logic signed [ACC_W:0]    accRnd;
  logic signed [ACC_W:0]    accShift;
  logic signed [DATA_W-1:0] satVal;

  assign prod = P_W'(coef[tapIdx]) * P_W'(dline[curCh][rdIdx]);

  // Round half-up one bit wider than the accumulator, then clamp to the output range.
  always_comb begin
    accRnd   = {acc[ACC_W-1], acc} + RND;
    accShift = accRnd >>> SHIFT;
    if (accShift > MAXV)
      satVal = {1'b0, {(DATA_W-1){1'b1}}};
    else if (accShift < MINV)
      satVal = {1'b1, {(DATA_W-1){1'b0}}};
    else
      satVal = accShift[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ready      <= 1'b1;
      dataReady  <= 1'b0;
      coefDrop   <= 1'b0;
      outSignal  <= '0;
      outChannel <= '0;
      curCh      <= '0;
      sampleReg  <= '0;
      tapIdx     <= '0;
      rdIdx      <= '0;
      acc        <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        ptr[c] <= '0;
        for (int t = 0; t < TAPS; t++) dline[c][t] <= '0;
      end
      for (int t = 0; t < TAPS; t++) coef[t] <= '0;
    end else begin
      dataReady <= 1'b0;
      coefDrop  <= 1'b0;

      // A write that coincides with an accepted sample lands before that sample's MAC pass.
      if (coefWe) begin
        if (state == IDLE && 32'(coefAddr) < 32'(TAPS))
          coef[coefAddr] <= coefData;
        else
          coefDrop <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (newData && 32'(inChannel) < 32'(CHANNELS)) begin
            curCh     <= inChannel;
            sampleReg <= inSignalUnReg;
            ready     <= 1'b0;
            state     <= WRITE;
          end
        end
        WRITE: begin
          dline[curCh][ptr[curCh]] <= sampleReg;
          acc    <= '0;
          tapIdx <= '0;
          rdIdx  <= ptr[curCh];
          state  <= MAC;
        end
        MAC: begin
          acc    <= acc + ACC_W'(prod);
          tapIdx <= tapIdx + 1'b1;
          rdIdx  <= (rdIdx == '0) ? LAST : rdIdx - 1'b1;
          if (tapIdx == LAST) state <= OUT;
        end
        OUT: begin
          outSignal  <= satVal;
          outChannel <= curCh;
          dataReady  <= 1'b1;
          ptr[curCh] <= (ptr[curCh] == LAST) ? '0 : ptr[curCh] + 1'b1;
          ready      <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/filter_fir_mc.md
# filter_fir_mc

Parametrised, multi-channel, fixed-point FIR filter with run-time programmable coefficients. It is the next-generation filter stage between the sample source and the FFT/UART back end. It time-multiplexes one multiply-accumulate unit over TAPS taps, keeps an independent delay line per channel, and returns rounded, saturated results with a channel tag and a one-cycle `dataReady` strobe.

## Interface
- `DATA_W`, 16: signed sample width, in and out.
- `COEF_W`, 16: signed coefficient width.
- `TAPS`, 11: filter length, ≥2.
- `CHANNELS`, 2: independent delay lines, ≥1; `CH_W = max(1, clog2(CHANNELS))`.
- `SHIFT`, 15: arithmetic right shift applied to the accumulator before saturation, 0..COEF_W.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `inSignalUnReg`  in  DATA_W  sample; captured only on acceptance.
- `inChannel`  in  CH_W  channel of the offered sample.
- `newData`  in  1  sample valid.
- `ready`  out  1  high when a sample can be accepted (state IDLE).
- `coefWe`  in  1  coefficient write strobe.
- `coefAddr`  in  clog2(TAPS)  tap index k.
- `coefData`  in  COEF_W  coefficient value.
- `coefDrop`  out  1  one-cycle pulse: the coefficient write was rejected.
- `outSignal`  out  DATA_W  filtered result, held until the next result.
- `outChannel`  out  CH_W  channel of `outSignal`.
- `dataReady`  out  1  one-cycle pulse: `outSignal`/`outChannel` updated.

## Operation
- Coefficients are shared by all channels: `coef[0..TAPS-1]`.
- Each channel c has a TAPS-word circular buffer `buf[c]` and a write pointer `ptr[c]`.
- Output y = sat(round(Σ_{k=0}^{TAPS-1} coef[k]·x[n−k] >>> SHIFT)).
- Accumulator width is `ACC_W = DATA_W + COEF_W + clog2(TAPS)`, so it never overflows.
- Rounding is half-up: when SHIFT>0, add `1<<(SHIFT-1)` before the arithmetic shift.
- Saturation clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- State machine:
  - IDLE: `ready=1`. `newData=1` with `inChannel<CHANNELS` latches the sample and channel and moves to WRITE. `newData` with `inChannel≥CHANNELS` is ignored, and the block stays in IDLE.
  - WRITE: writes the sample to `buf[ch][ptr[ch]]`, clears the accumulator, sets k=0, moves to MAC.
  - MAC: on each cycle, acc += coef[k]·buf[ch][(ptr[ch]−k) mod TAPS]; k++. After k=TAPS−1, moves to OUT.
  - OUT: registers the rounded/saturated acc into `outSignal`, sets `outChannel`, pulses `dataReady`, advances `ptr[ch]` (TAPS−1 wraps to 0), returns to IDLE.
- `newData` outside IDLE is ignored. There is no queueing, and the source must hold the sample or wait for `ready`.
- Coefficient writes:
  - `coefWe` in IDLE: writes `coef[coefAddr]` at the edge.
  - `coefWe` in any other state: dropped, with `coefDrop` pulsing in the following cycle.
  - `coefAddr≥TAPS`: dropped, with `coefDrop` pulsed.
  - Simultaneous `coefWe` and `newData` in IDLE: both are taken. The new coefficient applies to that sample's computation.
- Wrap-around: the (TAPS+1)-th sample on a channel overwrites that channel's oldest sample. Other channels are untouched.

## Timing
- Reset (`rst=0`, asynchronous):
  - State is IDLE.
  - `ready=1`, `dataReady=0`, `coefDrop=0`, `outSignal=0`, `outChannel=0`.
  - All `buf` words, all `ptr` values and all coefficients are cleared to 0.
- Reset asserted mid-computation aborts it: no `dataReady`, and the pointer is not advanced, because it is cleared anyway.
- Acceptance at edge E0 (`ready & newData`). `ready` falls after E0.
- The result is visible and `dataReady=1` in the cycle after edge E0+TAPS+2. Latency is TAPS+2 cycles.
- `ready` is high again in that same cycle, so the next acceptance can occur at E0+TAPS+3. The minimum sample period is TAPS+3 cycles.
- `outSignal` and `outChannel` are held until the next OUT state.

## Test plan
- **Reset:** assert `rst=0` mid-MAC.
  - Required: all outputs immediately go to their reset values and no `dataReady` follows.
  - Then an impulse yields a first output of coef[0]·1 rounded, confirming the buffer was cleared.
- **Impulse:** TAPS=11, SHIFT=0, coef[k]=k+1. On channel 0 feed 1 then 11 zeros.
  - Required: outputs 1,2,…,11,0.
  - Required: each `dataReady` arrives exactly 13 cycles after acceptance.
- **Channel isolation:** CHANNELS=2. Interleave a ch0 impulse with a ch1 constant 100 (coef[k]=k+1).
  - Required: ch0 outputs match the impulse test.
  - Required: ch1 outputs are 100, 300, 600, …, 6600, then steady at 6600. `outChannel` tags are correct.
- **Rounding:** SHIFT=15, coef[0]=16384, other coefficients 0.
  - Input 3 → 2. Input −3 → −1. Input 1 → 1.
- **Saturation:** DATA_W=16, SHIFT=0, all coefficients 0x7FFF.
  - Repeated 32767 → 32767.
  - Repeated −32768 → −32768.
- **Drops:**
  - `newData` asserted during MAC → ignored, and exactly one `dataReady` results.
  - `coefWe` during MAC → `coefDrop` pulses and the coefficient is unchanged.
  - `coefAddr=11` with TAPS=11 → `coefDrop` pulses.
